// File: rtl/turn_timer_ctrl.sv
// Per-turn countdown sequencer: 1 s prescaler, start/reload/pause/abort
// handling, and a one-cycle timeout pulse when a turn expires.
module turn_timer_ctrl #(
  parameter int unsigned TICK_CYCLES = 50_000_000,
  parameter int unsigned TURN_SECS   = 10,
  parameter int unsigned PRESC_W     = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       move_done,
  input  logic       pause,
  input  logic       abort,
  output logic [3:0] seconds,
  output logic       running,
  output logic       timeout,
  output logic [1:0] state
);

  localparam int unsigned SEC_W = 4;
  localparam logic [SEC_W-1:0]   SEC_BLANK = SEC_W'(15);
  localparam logic [SEC_W-1:0]   SEC_LOAD  = SEC_W'(TURN_SECS);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t             state_q, state_n;
  logic [SEC_W-1:0]   sec_q, sec_n;
  logic [PRESC_W-1:0] presc_q, presc_n;
  logic               running_q, running_n;
  logic               timeout_q, timeout_n;
  logic               tick;

  assign tick    = (presc_q == PRESC_MAX);
  assign seconds = sec_q;
  assign running = running_q;
  assign timeout = timeout_q;
  assign state   = state_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sec_q     <= SEC_BLANK;
      presc_q   <= '0;
      running_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      sec_q     <= sec_n;
      presc_q   <= presc_n;
      running_q <= running_n;
      timeout_q <= timeout_n;
    end
  end

  // Next-state and datapath update; priority abort > start > move_done > pause > tick
  always_comb begin
    state_n   = state_q;
    sec_n     = sec_q;
    presc_n   = presc_q;
    timeout_n = 1'b0;

    if (abort) begin
      state_n = IDLE;
      sec_n   = SEC_BLANK;
      presc_n = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_n = RUN;
            sec_n   = SEC_LOAD;
            presc_n = '0;
          end
        end
        RUN: begin
          if (start || move_done) begin
            sec_n   = SEC_LOAD;
            presc_n = '0;
          end else if (pause) begin
            state_n = PAUSED;
          end else if (tick) begin
            presc_n = '0;
            if (sec_q == SEC_W'(1)) begin
              state_n   = EXPIRED;
              sec_n     = '0;
              timeout_n = 1'b1;
            end else if (sec_q != '0) begin
              sec_n = sec_q - SEC_W'(1);
            end
          end else begin
            presc_n = presc_q + PRESC_W'(1);
          end
        end
        PAUSED: begin
          if (start) begin
            state_n = RUN;
            sec_n   = SEC_LOAD;
            presc_n = '0;
          end else if (!pause) begin
            state_n = RUN;
          end
        end
        EXPIRED: begin
          sec_n = '0;
          if (start) begin
            state_n = RUN;
            sec_n   = SEC_LOAD;
            presc_n = '0;
          end
        end
        default: begin
          state_n = IDLE;
          sec_n   = SEC_BLANK;
          presc_n = '0;
        end
      endcase
    end
  end

  // running is registered alongside state so the two always agree
  assign running_n = (state_n == RUN);

endmodule

// File: tb/tb_turn_timer_ctrl.sv
// Directed, table-driven bench for turn_timer_ctrl with TICK_CYCLES=4, TURN_SECS=3.
module tb_turn_timer_ctrl;

  localparam int unsigned TICK = 4;
  localparam int unsigned TURN = 3;
  localparam int unsigned PW   = 3;
  localparam int unsigned MAXV = 96;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, move_done, pause, abort;
  logic [3:0] seconds;
  logic       running, timeout;
  logic [1:0] state;

  int pass_cnt  = 0;
  int check_cnt = 0;

  typedef struct {
    logic       st;
    logic       md;
    logic       pa;
    logic       ab;
    logic [3:0] sec;
    logic [1:0] stt;
    logic       to;
  } vec_t;

  vec_t vecs [MAXV];
  int   nvec = 0;

  turn_timer_ctrl #(.TICK_CYCLES(TICK), .TURN_SECS(TURN), .PRESC_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .move_done(move_done), .pause(pause),
    .abort(abort), .seconds(seconds), .running(running), .timeout(timeout),
    .state(state)
  );

  always #5 clk = ~clk;

  // Append one record: inputs for the next edge and outputs expected after it
  task automatic v(input logic st, input logic md, input logic pa, input logic ab,
                   input int sec, input int stt, input logic to);
    vecs[nvec].st  = st;
    vecs[nvec].md  = md;
    vecs[nvec].pa  = pa;
    vecs[nvec].ab  = ab;
    vecs[nvec].sec = 4'(sec);
    vecs[nvec].stt = 2'(stt);
    vecs[nvec].to  = to;
    nvec++;
  endtask

  // Compare {seconds,state,running,timeout} against the expected tuple
  task automatic chk(input string name, input int sec, input int stt, input logic to);
    logic [7:0] act, exp;
    act = {seconds, state, running, timeout};
    exp = {4'(sec), 2'(stt), (2'(stt) == 2'd1), to};
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got sec=%0d st=%0d run=%0b to=%0b, want sec=%0d st=%0d run=%0b to=%0b",
                  name, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
  endtask

  task automatic drive(input logic st, input logic md, input logic pa, input logic ab);
    start = st; move_done = md; pause = pa; abort = ab;
  endtask

  task automatic edge_step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0);
    rst = 1'b1;

    // Full countdown from start to expiry
    v(1,0,0,0, 3,1,0);
    v(0,0,0,0, 3,1,0); v(0,0,0,0, 3,1,0); v(0,0,0,0, 3,1,0);
    v(0,0,0,0, 2,1,0);
    v(0,0,0,0, 2,1,0); v(0,0,0,0, 2,1,0); v(0,0,0,0, 2,1,0);
    v(0,0,0,0, 1,1,0);
    v(0,0,0,0, 1,1,0); v(0,0,0,0, 1,1,0); v(0,0,0,0, 1,1,0);
    v(0,0,0,0, 0,3,1);
    v(0,0,0,0, 0,3,0);
    v(0,1,1,0, 0,3,0);
    // Restart from EXPIRED, then reload on the edge a tick is due
    v(1,0,0,0, 3,1,0);
    v(0,0,0,0, 3,1,0); v(0,0,0,0, 3,1,0); v(0,0,0,0, 3,1,0);
    v(0,0,0,0, 2,1,0);
    v(0,0,0,0, 2,1,0); v(0,0,0,0, 2,1,0); v(0,0,0,0, 2,1,0);
    v(0,1,0,0, 3,1,0);
    v(0,0,0,0, 3,1,0); v(0,0,0,0, 3,1,0); v(0,0,0,0, 3,1,0);
    v(0,0,0,0, 2,1,0);
    // Pause at seconds=2, prescaler=1 for ten cycles
    v(0,0,0,0, 2,1,0);
    for (int i = 0; i < 10; i++) v(0,0,1,0, 2,2,0);
    v(0,1,0,0, 2,1,0);
    v(0,0,0,0, 2,1,0); v(0,0,0,0, 2,1,0);
    v(0,0,0,0, 1,1,0);
    // Start while paused reloads; pause re-enters on the next cycle
    v(0,0,0,0, 1,1,0);
    v(0,0,1,0, 1,2,0);
    v(1,0,1,0, 3,1,0);
    v(0,0,1,0, 3,2,0);
    v(0,0,0,0, 3,1,0);
    v(0,0,0,0, 3,1,0); v(0,0,0,0, 3,1,0); v(0,0,0,0, 3,1,0);
    v(0,0,0,0, 2,1,0);
    // Abort and IDLE input filtering
    v(0,0,0,1, 15,0,0);
    v(0,1,0,0, 15,0,0);
    v(0,0,1,0, 15,0,0);
    v(1,0,0,1, 15,0,0);
    v(1,1,0,0, 3,1,0);
    v(0,0,1,1, 15,0,0);

    #12;
    chk("reset", 15, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_hold", 15, 0, 0);

    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].st, vecs[i].md, vecs[i].pa, vecs[i].ab);
      edge_step();
      chk($sformatf("vec%0d", i), vecs[i].sec, vecs[i].stt, vecs[i].to);
    end

    // Asynchronous reset between edges mid-count
    drive(1, 0, 0, 0); edge_step(); drive(0, 0, 0, 0);
    edge_step(); edge_step();
    chk("pre_rst", 3, 1, 0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst", 15, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    // Prescaler must restart from zero after reset
    drive(1, 0, 0, 0); edge_step(); drive(0, 0, 0, 0);
    edge_step(); edge_step(); edge_step();
    chk("after_rst_p3", 3, 1, 0);
    edge_step();
    chk("after_rst_dec", 2, 1, 0);

    // Reset just before expiry yields no timeout pulse
    for (int i = 0; i < 7; i++) edge_step();
    chk("pre_expire", 1, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    edge_step();
    chk("rst_no_to", 15, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    edge_step();
    chk("rst_no_to2", 15, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
